// File: rtl/inv_mixcolumns_iter.sv
// inv_mixcolumns_iter
//   Iterative AES InverseMixColumns. A captured 128-bit state is transformed
//   one 32-bit column per cycle by the circulant matrix {0e 0b 0d 09} over
//   GF(2^8) (poly 0x11B). Only a single column of multiplier logic is used.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   i_valid  upstream offers i_block
//   i_ready  block can accept i_block this cycle (combinational, never
//            depends on i_valid)
//   i_block  input state, column-major; column c = [127-32c -: 32],
//            row r of column c = [127-32c-8r -: 8]
//   o_valid  o_block holds a completed result
//   o_ready  downstream accepts o_block this cycle
//   o_block  result state, same byte layout as i_block

// One output byte of an InvMixColumns column. Inputs are the column bytes
// rotated so that i_a0 is the byte on the output's own row:
//   o_r = 14*a0 ^ 11*a1 ^ 13*a2 ^ 9*a3
module inv_mix_row (
  input  logic [7:0] i_a0,
  input  logic [7:0] i_a1,
  input  logic [7:0] i_a2,
  input  logic [7:0] i_a3,
  output logic [7:0] o_r
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples built from the chained xtime terms x2, x4, x8.
  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction
  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction
  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction
  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  assign o_r = mul14(i_a0) ^ mul11(i_a1) ^ mul13(i_a2) ^ mul9(i_a3);
endmodule

module inv_mixcolumns_iter #(
  parameter int NB   = 4,
  parameter int WORD = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [NB*NB*WORD-1:0]   i_block,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [NB*NB*WORD-1:0]   o_block
);
  localparam int CW = NB*WORD;     // bits per column
  localparam int BW = NB*CW;       // bits per block

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_col;
  logic [BW-1:0]   r_in;
  logic [BW-1:0]   r_out;
  logic            r_valid;

  logic [CW-1:0]   w_col;
  logic [CW-1:0]   w_res;

  // Column 0 sits in the top bits, so column index counts down from MSB.
  assign w_col = r_in[(NB-1-int'(r_col))*CW +: CW];

  for (genvar r = 0; r < NB; r++) begin : g_row
    inv_mix_row u_row (
      .i_a0 (w_col[(NB-1-r)*WORD          +: WORD]),
      .i_a1 (w_col[(NB-1-((r+1)%NB))*WORD +: WORD]),
      .i_a2 (w_col[(NB-1-((r+2)%NB))*WORD +: WORD]),
      .i_a3 (w_col[(NB-1-((r+3)%NB))*WORD +: WORD]),
      .o_r  (w_res[(NB-1-r)*WORD          +: WORD])
    );
  end

  // DONE with o_ready lets a new block in on the same edge as the hand-off.
  assign i_ready = (r_state == IDLE) || ((r_state == DONE) && o_ready);
  assign o_valid = r_valid;
  assign o_block = r_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_in    <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_in    <= i_block;
            r_col   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_out[(NB-1-int'(r_col))*CW +: CW] <= w_res;
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (o_ready) begin
            r_valid <= 1'b0;
            if (i_valid) begin
              r_in    <= i_block;
              r_col   <= '0;
              r_state <= BUSY;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
module tb_inv_mixcolumns_iter;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         i_ready;
  logic [127:0] i_block;
  logic         o_valid;
  logic         o_ready;
  logic [127:0] o_block;

  inv_mixcolumns_iter #(.NB(4), .WORD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_block (i_block),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_block (o_block)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc;
  logic acc_ovalid;
  bit   rnd_ready = 0;
  logic [127:0] exp_q[$];

  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix multiply per column; inv selects {0e 0b 0d 09}
  // versus the forward {02 03 01 01}.
  function automatic logic [127:0] mixcols(input logic [127:0] s, input bit inv);
    logic [7:0]   cf[4];
    logic [7:0]   acc;
    logic [127:0] o = '0;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(cf[(j - r + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && o_valid === 1'b1 && o_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", o_block);
      end else begin
        chk("result", o_block, exp_q.pop_front());
      end
    end
  end

  // Random downstream back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) o_ready = 1'($urandom_range(0, 1));
  end

  // Called #1 after a posedge; returns #1 after the accept edge.
  task automatic send(input logic [127:0] blk, input logic [127:0] exp);
    bit ok = 0;
    i_valid = 1'b1;
    i_block = blk;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (i_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no i_ready expected accept");
    end else begin
      exp_q.push_back(exp);
      last_acc   = cyc + 1;
      acc_ovalid = o_valid;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    // Scramble i_block after accept; the captured copy must be unaffected.
    i_block = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin @(posedge clk); k++; end
    #1;
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] a, b, hold, orig;
    int k, prev, seen;
    rst = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_block = '0;

    // Asynchronous reset mid-cycle.
    #3 rst = 1'b1;
    #1;
    chk("reset_o_valid", 128'(o_valid), 128'd0);
    chk("reset_o_block", o_block, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 chk("reset_i_ready", 128'(i_ready), 128'd1);
    seen = 0;
    repeat (6) begin @(negedge clk); if (o_valid) seen++; end
    chk("idle_no_valid", 128'(seen), 128'd0);

    // FIPS vector with latency measurement.
    @(posedge clk); #1;
    o_ready = 1'b1;
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
         128'hdb135345_f20a225c_01010101_c6c6c6c6);
    for (k = 0; k < 10; k++) begin @(negedge clk); if (o_valid) break; end
    chk("latency", 128'(k), 128'd4);
    @(posedge clk); #1;
    send(128'hd5d5d7d6_8e4da1bc_01010101_c6c6c6c6,
         128'hd4d4d4d5_db135345_01010101_c6c6c6c6);
    wait_drain(50);

    // Back-pressure: result held, competing input refused.
    @(posedge clk); #1;
    o_ready = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    send(a, mixcols(a, 1));
    for (k = 0; k < 20; k++) begin @(negedge clk); if (o_valid) break; end
    chk("bp_valid", 128'(o_valid), 128'd1);
    hold = o_block;
    @(posedge clk); #1;
    i_valid = 1'b1; i_block = b;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", o_block, hold);
      chk("bp_i_ready", 128'(i_ready), 128'd0);
    end
    @(posedge clk); #1;
    o_ready = 1'b1;
    send(b, mixcols(b, 1));
    wait_drain(50);

    // Back-to-back with o_ready high.
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      prev = last_acc;
      send(a, mixcols(a, 1));
      if (n > 0) begin
        chk("b2b_spacing", 128'(last_acc - prev), 128'd5);
        chk("b2b_handoff_valid", 128'(acc_ovalid), 128'd1);
      end
    end
    wait_drain(50);

    // Reset two cycles into BUSY.
    @(posedge clk); #1;
    a = {$urandom, $urandom, $urandom, $urandom};
    send(a, mixcols(a, 1));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_o_valid", 128'(o_valid), 128'd0);
    chk("midrst_o_block", o_block, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 chk("midrst_i_ready", 128'(i_ready), 128'd1);
    seen = 0;
    repeat (8) begin @(negedge clk); if (o_valid) seen++; end
    chk("midrst_no_valid", 128'(seen), 128'd0);
    @(posedge clk); #1;
    b = {$urandom, $urandom, $urandom, $urandom};
    send(b, mixcols(b, 1));
    wait_drain(50);

    // Round trip: forward MixColumns in, original block expected out.
    rnd_ready = 1;
    @(posedge clk); #1;
    for (int n = 0; n < 200; n++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      k = $urandom_range(0, 2);
      repeat (k) begin @(posedge clk); #1; end
      send(mixcols(orig, 0), orig);
    end
    wait_drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
